mem_arbiter: RTL

//  Shares one single-port synchronous memory (DP_mem32x64k, 1-cycle read latency) between
//  the instruction-fetch port and the execute-stage data port (load/store). Grants at most one

---
 rtl/mem_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between instruction fetch and data
// load/store, data first, with a starvation counter that guarantees fetch forward progress.
module mem_arbiter #(
    parameter int ADDR     = 16,
    parameter int WORD     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    input  logic            i_kill,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [WORD-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_t;

    owner_t          r_owner;
    owner_t          w_owner_nxt;
    logic [CW-1:0]   r_wait;
    logic [CW-1:0]   w_wait_nxt;
    logic            w_starve;

    assign w_starve = (r_wait == CW'(MAX_WAIT));
    // rst gates the grants so nothing reaches the memory while reset is held
    assign i_gnt    = rst & i_req & (~d_req | w_starve);
    assign d_gnt    = rst & d_req & ~(i_req & w_starve);
    assign mem_a    = d_gnt ? d_addr : i_addr;
    assign mem_w    = d_gnt & d_we;
    assign mem_d    = d_wdata;
    assign i_rdata  = mem_q;
    assign d_rdata  = mem_q;

    always_comb begin
        w_wait_nxt = (i_req & ~i_gnt) ? (w_starve ? r_wait : r_wait + CW'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_NONE;
            r_wait  <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_owner_nxt = (i_gnt & ~i_kill) ? OWN_IF : (d_gnt & ~d_we) ? OWN_DATA : OWN_NONE;
    end

    always_comb begin
        i_rvalid = (r_owner == OWN_IF) & ~i_kill;
        d_rvalid = (r_owner == OWN_DATA);
    end
endmodule
